usb_rx_phy: RTL and testbench
=============================

// Module: usb_rx_phy
// PURPOSE
//  Low-speed (1.5 Mb/s) USB receive front end; feeds the SIE packet decoder inside usb_device_controller.
//  Synchronises raw D+/D-, recovers bit timing (DPLL), detects SYNC, NRZI-decodes, removes stuffed bits.
//  Assembles LSB-first bytes; flags EOP and line errors.
//  Output is a byte stream with an rx_active packet envelope.
// PARAMETERS
//  CLKS_PER_BIT  16   clk cycles per bit; 24 MHz / 1.5 Mb/s. Must be an even number >= 8.
//  RESET_CLKS    60   SE0 cycles that signal a USB bus reset (2.5 us at 24 MHz); used only with USB_RX_BUS_RESET_EN.
// PORTS
//  clk        in   1  system clock, 24 MHz
//  reset_n    in   1  asynchronous, active-low reset
//  d_i        in   2  d_port_t: bit1 = D-, bit0 = D+. Raw pins, asynchronous to clk.
//  rx_en      in   1  0 = receiver forced to IDLE; driven low while the transmitter owns the bus
//  rx_data    out  8  last completed byte; LSB = first bit received
//  rx_valid   out  1  1-cycle strobe; rx_data is new
//  rx_active  out  1  high from SYNC completion to EOP or error
//  rx_error   out  1  1-cycle strobe on stuff, EOP or line error
//  usb_reset  out  1  bus reset detected (level); see CONFIGURATION
// BEHAVIOUR
//  Reset values: rx_data=8'h00; rx_valid, rx_active, rx_error, usb_reset = 0; FSM = IDLE.
//  Input sync: 2-FF synchroniser on both lines.
//  Line states (low speed): J=2'b10, K=2'b01, SE0=2'b00, SE1=2'b11.
//  DPLL: phase counter 0..CLKS_PER_BIT-1, wraps to 0.
//    - Any change of the synchronised line state reloads the counter to 0.
//    - A sample is taken when the counter equals CLKS_PER_BIT/2-1.
//    - Tolerates bit periods of CLKS_PER_BIT +/- 1 clk.
//  NRZI decode: decoded bit = 1 if the sample equals the previous sample, else 0.
//  FSM states: IDLE, SYNC, DATA, EOP, ERROR.
//   IDLE : on a J->K transition go to SYNC. Previous-sample register is preset to J.
//   SYNC : expect alternating K/J samples ending in K,K.
//     - K,K seen: rx_active=1 next cycle, go to DATA. Stuff counter and bit counter cleared.
//     - SE0 or SE1 sampled, or 8 samples without K,K: back to IDLE silently. No rx_error.
//   DATA : each sample is decoded.
//     - Decoded 1 increments the ones counter; decoded 0 clears it.
//     - After 6 ones the next bit is a stuff bit. A decoded 0 is discarded, ones counter cleared.
//     - Stuff bit decoded as 1: rx_error pulse, rx_active=0, go to ERROR.
//     - Data bits shift in LSB-first.
//     - 8th bit: rx_data updated and rx_valid=1 in the clk cycle after that bit's sample. Bit counter wraps to 0.
//     - SE1 sampled: error path (as stuff error).
//     - SE0 sampled: go to EOP.
//     - A stuff bit and SE0 never coincide; SE0 wins.
//   EOP  : accept 1 or 2 SE0 samples, then J.
//     - On J: rx_active=0.
//     - Residual bit count 0 or 1 (dribble): no error.
//     - Residual bit count 2..7: rx_error pulse, same cycle as rx_active falls.
//     - K, SE1, or a 3rd SE0 sample: rx_error pulse, rx_active=0, go to ERROR.
//     - After J, go to IDLE.
//   ERROR: wait for SE0 followed by J, or 8 consecutive J samples, then go to IDLE.
//  rx_en=0 (any state): next cycle FSM=IDLE and rx_active=0. No rx_error, no rx_valid.
//  rx_valid and rx_error never assert outside an rx_active envelope, except in the falling-edge cycle.
//  Asynchronous reset mid-packet: all state cleared immediately. The next packet needs a fresh SYNC.
// CONFIGURATION
//  USB_RX_BUS_RESET_EN defined:
//    - Counter of consecutive synchronised SE0 cycles, saturating at RESET_CLKS.
//    - usb_reset=1 while the count equals RESET_CLKS; returns to 0 on the first non-SE0 cycle.
//    - Counter runs independently of rx_en and the FSM.
//  USB_RX_BUS_RESET_EN undefined: usb_reset tied to 0; no counter logic.
// TESTING
//  1. SYNC + byte 8'h69 + EOP (SE0 x2 bits, J), 16 clk/bit
//     -> one rx_valid, rx_data=8'h69, rx_active high ~8 bits, rx_error never.
//  2. SYNC + 8'hFF, 8'hFF with a stuff 0 after every 6 ones + EOP
//     -> two rx_valid, both 8'hFF, no rx_error.
//  3. SYNC + 7 consecutive decoded ones (no stuff bit)
//     -> rx_error pulse on the 7th bit, rx_active=0; the next valid packet is received normally.
//  4. Test 1 with bit period 15 clk, then 17 clk
//     -> rx_data=8'h69 in both cases. Also: EOP after 3 residual bits -> rx_error at EOP.
//  5. reset_n low mid-byte, or rx_en=0 mid-packet
//     -> rx_active=0 at once / next cycle, no rx_valid, then clean receipt of 8'hC3.
//  6. (USB_RX_BUS_RESET_EN) SE0 for 59 clk -> usb_reset stays 0; SE0 for 60 clk -> usb_reset=1 until J.

Source files
------------

// File: rtl/usb_rx_phy.sv
// usb_rx_phy -- low-speed (1.5 Mb/s) USB receive front end.
//   Synchronises raw D+/D-, recovers bit timing with a simple DPLL, detects
//   SYNC, NRZI-decodes, strips stuffed bits and assembles LSB-first bytes.
//   Optional bus-reset detector is compiled in with `define USB_RX_BUS_RESET_EN.
// Ports:
//   clk        system clock (24 MHz)
//   reset_n    asynchronous active-low reset
//   d_i[1:0]   raw pins, bit1 = D-, bit0 = D+ (asynchronous to clk)
//   rx_en      0 forces the receiver to IDLE (transmitter owns the bus)
//   rx_data    last completed byte, LSB = first bit on the wire
//   rx_valid   1-cycle strobe, rx_data is new
//   rx_active  packet envelope: SYNC completion to EOP/error
//   rx_error   1-cycle strobe on stuff, EOP or line error
//   usb_reset  bus reset detected (level), 0 when the detector is not built
module usb_rx_phy #(
  parameter int CLKS_PER_BIT = 16,
  parameter int RESET_CLKS   = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] d_i,
  input  logic       rx_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       rx_error,
  output logic       usb_reset
);

  localparam int PW = $clog2(CLKS_PER_BIT);
  localparam logic [PW-1:0] PH_SAMPLE = PW'(CLKS_PER_BIT/2 - 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] LS_J   = 2'b10;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_SE1 = 2'b11;

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ERROR} state_t;

  // Synchroniser flops reset to J so a reset on an idle bus sees no edge.
  logic [1:0]    meta_q, line_q, line_prev_q;
  logic [PW-1:0] phase_q, phase_d;
  state_t        state_q, state_d;
  logic [1:0]    samp_q, samp_d;
  logic [2:0]    cnt_q, cnt_d;      // SYNC samples / EOP SE0 samples / ERROR J run
  logic [2:0]    ones_q, ones_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          error_q, error_d;
  logic          se0_seen_q, se0_seen_d;

  logic line_chg, sample, bit_dec, is_jk;

  assign line_chg = (line_q != line_prev_q);
  // Never sample on the cycle the counter is being realigned.
  assign sample   = !line_chg && (phase_q == PH_SAMPLE);
  assign bit_dec  = (line_q == samp_q);
  assign is_jk    = (line_q == LS_J) || (line_q == LS_K);

  always_comb begin
    if (line_chg || phase_q == PH_LAST) phase_d = '0;
    else                                phase_d = phase_q + PW'(1);
  end

  always_comb begin
    state_d    = state_q;
    samp_d     = samp_q;
    cnt_d      = cnt_q;
    ones_d     = ones_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    error_d    = 1'b0;
    se0_seen_d = se0_seen_q;
    unique case (state_q)
      IDLE: begin
        if (line_chg && line_prev_q == LS_J && line_q == LS_K) begin
          state_d = SYNC;
          samp_d  = LS_J;
          cnt_d   = '0;
        end
      end
      SYNC: begin
        if (sample) begin
          samp_d = line_q;
          if (!is_jk) state_d = IDLE;
          else if (line_q == LS_K && samp_q == LS_K) begin
            state_d = DATA;
            ones_d  = '0;
            bit_d   = '0;
          end
          else if (cnt_q == 3'd7) state_d = IDLE;
          else cnt_d = cnt_q + 3'd1;
        end
      end
      DATA: begin
        if (sample) begin
          if (line_q == LS_SE0) begin
            state_d = EOP;
            cnt_d   = 3'd1;
          end else if (line_q == LS_SE1) begin
            error_d    = 1'b1;
            state_d    = ERROR;
            cnt_d      = '0;
            se0_seen_d = 1'b0;
          end else begin
            samp_d = line_q;
            if (ones_q == 3'd6) begin
              // Stuff bit slot: a 0 is dropped, a 1 breaks the stuffing rule.
              if (bit_dec) begin
                error_d    = 1'b1;
                state_d    = ERROR;
                cnt_d      = '0;
                se0_seen_d = 1'b0;
              end else ones_d = '0;
            end else begin
              ones_d  = bit_dec ? ones_q + 3'd1 : 3'd0;
              shift_d = {bit_dec, shift_q[7:1]};
              bit_d   = bit_q + 3'd1;
              if (bit_q == 3'd7) begin
                data_d  = {bit_dec, shift_q[7:1]};
                valid_d = 1'b1;
              end
            end
          end
        end
      end
      EOP: begin
        if (sample) begin
          if (line_q == LS_SE0 && cnt_q == 3'd1) cnt_d = 3'd2;
          else if (line_q == LS_J) begin
            state_d = IDLE;
            // 0 or 1 dribble bits are tolerated.
            error_d = (bit_q >= 3'd2);
          end else begin
            error_d    = 1'b1;
            state_d    = ERROR;
            cnt_d      = '0;
            se0_seen_d = (line_q == LS_SE0);
          end
        end
      end
      ERROR: begin
        if (sample) begin
          if (line_q == LS_SE0) begin
            se0_seen_d = 1'b1;
            cnt_d      = '0;
          end else if (line_q == LS_J) begin
            if (se0_seen_q || cnt_q == 3'd7) state_d = IDLE;
            else cnt_d = cnt_q + 3'd1;
          end else begin
            se0_seen_d = 1'b0;
            cnt_d      = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rx_en) begin
      state_d = IDLE;
      valid_d = 1'b0;
      error_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q      <= LS_J;
      line_q      <= LS_J;
      line_prev_q <= LS_J;
      phase_q     <= '0;
      state_q     <= IDLE;
      samp_q      <= LS_J;
      cnt_q       <= '0;
      ones_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      se0_seen_q  <= 1'b0;
    end else begin
      meta_q      <= d_i;
      line_q      <= meta_q;
      line_prev_q <= line_q;
      phase_q     <= phase_d;
      state_q     <= state_d;
      samp_q      <= samp_d;
      cnt_q       <= cnt_d;
      ones_q      <= ones_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
      se0_seen_q  <= se0_seen_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_error  = error_q;
  assign rx_active = (state_q == DATA) || (state_q == EOP);

`ifdef USB_RX_BUS_RESET_EN
  localparam int RW = $clog2(RESET_CLKS + 1);
  logic [RW-1:0] se0_cnt_q;

  // Free-running: bus reset must be seen regardless of rx_en or FSM state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         se0_cnt_q <= '0;
    else if (line_q != LS_SE0)            se0_cnt_q <= '0;
    else if (se0_cnt_q != RW'(RESET_CLKS)) se0_cnt_q <= se0_cnt_q + RW'(1);
  end

  assign usb_reset = (se0_cnt_q == RW'(RESET_CLKS));
`else
  assign usb_reset = 1'b0;
`endif

endmodule

// File: tb/tb_usb_rx_phy.sv
// Scoreboard bench for usb_rx_phy: stimulus tasks push the expected byte /
// error events into a queue, a negedge monitor pops and compares them.
module tb_usb_rx_phy;
  localparam int CPB = 16;
  localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00;

  logic       clk = 1'b0;
  logic       reset_n, rx_en;
  logic [1:0] d_i;
  logic [7:0] rx_data;
  logic       rx_valid, rx_active, rx_error, usb_reset;

  always #5 clk = ~clk;

  usb_rx_phy #(.CLKS_PER_BIT(CPB), .RESET_CLKS(60)) dut (
    .clk(clk), .reset_n(reset_n), .d_i(d_i), .rx_en(rx_en),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_active(rx_active),
    .rx_error(rx_error), .usb_reset(usb_reset)
  );

  int n_chk = 0, n_fail = 0;
  logic [8:0] exp_q[$];   // {is_error, byte}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor
  logic act_prev = 1'b0;
  always @(negedge clk) begin
    logic [8:0] e;
    if (reset_n && (rx_valid || rx_error)) begin
      check("envelope", {31'd0, rx_active | act_prev}, 32'd1);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event: valid=%0b error=%0b data=%0h, none expected", rx_valid, rx_error, rx_data);
      end else begin
        e = exp_q.pop_front();
        if (e[8]) check("rx_error", {31'd0, rx_error}, 32'd1);
        else begin
          check("rx_valid", {31'd0, rx_valid}, 32'd1);
          check("rx_data", {24'd0, rx_data}, {24'd0, e[7:0]});
        end
      end
    end
    act_prev <= rx_active;
  end

  // Line drivers
  logic [1:0] cur;
  int ones;

  task automatic hold(input logic [1:0] s, input int n);
    @(negedge clk) d_i = s;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic tx_raw(input bit b, input int per);
    if (!b) cur = (cur == J) ? K : J;
    hold(cur, per);
  endtask

  task automatic tx_bit(input bit b, input int per, input bit stuff);
    tx_raw(b, per);
    if (b) ones++; else ones = 0;
    if (stuff && ones == 6) begin
      tx_raw(1'b0, per);
      ones = 0;
    end
  endtask

  task automatic tx_sync(input int per);
    cur = J;
    for (int i = 0; i < 7; i++) tx_raw(1'b0, per);
    tx_raw(1'b1, per);
    ones = 0;
  endtask

  task automatic tx_byte(input logic [7:0] b, input int per);
    for (int i = 0; i < 8; i++) tx_bit(b[i], per, 1'b1);
  endtask

  task automatic tx_eop(input int per);
    hold(SE0, 2 * per);
    hold(J, per);
    cur = J;
    hold(J, 4 * per);
  endtask

  task automatic packet(input logic [7:0] b, input int per, input string tag);
    exp_q.push_back({1'b0, b});
    tx_sync(per);
    tx_byte(b, per);
    check({tag, "_active_in"}, {31'd0, rx_active}, 32'd1);
    tx_eop(per);
    check({tag, "_active_out"}, {31'd0, rx_active}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    d_i = J; rx_en = 1'b1; reset_n = 1'b0; cur = J; ones = 0;
    repeat (4) @(negedge clk);
    check("rst_data",   {24'd0, rx_data},    32'h00);
    check("rst_valid",  {31'd0, rx_valid},   32'd0);
    check("rst_active", {31'd0, rx_active},  32'd0);
    check("rst_error",  {31'd0, rx_error},   32'd0);
    check("rst_busrst", {31'd0, usb_reset},  32'd0);
    reset_n = 1'b1;
    hold(J, 4 * CPB);

    // 1: basic byte
    packet(8'h69, CPB, "t1");

    // 2: two 0xFF bytes with stuffing
    exp_q.push_back({1'b0, 8'hFF});
    exp_q.push_back({1'b0, 8'hFF});
    tx_sync(CPB);
    tx_byte(8'hFF, CPB);
    tx_byte(8'hFF, CPB);
    tx_eop(CPB);
    check("t2_active_out", {31'd0, rx_active}, 32'd0);

    // 3: seven ones without stuff bit -> stuff error, then recovery
    exp_q.push_back({1'b1, 8'h00});
    tx_sync(CPB);
    for (int i = 0; i < 7; i++) tx_bit(1'b1, CPB, 1'b0);
    check("t3_active_err", {31'd0, rx_active}, 32'd0);
    tx_eop(CPB);
    packet(8'h69, CPB, "t3_recov");

    // 4: bit period tolerance, then residual bits at EOP
    packet(8'h69, CPB - 1, "t4_p15");
    packet(8'h69, CPB + 1, "t4_p17");
    exp_q.push_back({1'b0, 8'h69});
    exp_q.push_back({1'b1, 8'h00});
    tx_sync(CPB);
    tx_byte(8'h69, CPB);
    tx_bit(1'b1, CPB, 1'b1);
    tx_bit(1'b0, CPB, 1'b1);
    tx_bit(1'b1, CPB, 1'b1);
    tx_eop(CPB);
    check("t4_resid_active", {31'd0, rx_active}, 32'd0);

    // Aborted SYNC (K then SE0): silent return to IDLE
    hold(K, CPB);
    hold(SE0, 2 * CPB);
    hold(J, 4 * CPB);
    check("sync_abort_active", {31'd0, rx_active}, 32'd0);

    // 5a: async reset mid-byte
    tx_sync(CPB);
    for (int i = 0; i < 4; i++) tx_bit(i[0], CPB, 1'b1);
    check("t5a_active_pre", {31'd0, rx_active}, 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("t5a_active_rst", {31'd0, rx_active}, 32'd0);
    check("t5a_data_rst",   {24'd0, rx_data},   32'h00);
    d_i = J; cur = J;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    hold(J, 4 * CPB);
    packet(8'hC3, CPB, "t5a_c3");

    // 5b: rx_en dropped mid-packet
    tx_sync(CPB);
    for (int i = 0; i < 4; i++) tx_bit(i[0], CPB, 1'b1);
    check("t5b_active_pre", {31'd0, rx_active}, 32'd1);
    @(negedge clk);
    rx_en = 1'b0;
    @(negedge clk);
    check("t5b_active_dis", {31'd0, rx_active}, 32'd0);
    hold(J, 4 * CPB);
    cur = J;
    rx_en = 1'b1;
    hold(J, 4 * CPB);
    packet(8'hC3, CPB, "t5b_c3");

`ifdef USB_RX_BUS_RESET_EN
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 59; i++) begin
        @(negedge clk) d_i = SE0;
        if (usb_reset) seen = 1'b1;
      end
      for (int i = 0; i < 6; i++) begin
        @(negedge clk) d_i = J;
        if (usb_reset) seen = 1'b1;
      end
      check("t6_se0_59", {31'd0, seen}, 32'd0);
      hold(SE0, 70);
      check("t6_se0_70", {31'd0, usb_reset}, 32'd1);
      hold(J, 4);
      check("t6_release", {31'd0, usb_reset}, 32'd0);
      hold(J, 4 * CPB);
    end
`endif

    hold(J, 2 * CPB);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
